// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam logic [15:0] UARTBASE_DEFAULT = 16'h0ff0;
  localparam int          WAIT_W           = 4;

  // Unsigned compare: the base address itself belongs to UART space.
  function automatic logic in_uart_space(input logic [15:0] addr,
                                         input logic [15:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side handshakes plus the downstream bus, bundled for the arbiter.
interface bus_arbiter_if;
  logic        m0_req,   m1_req;
  logic        m0_we,    m1_we;
  logic        m0_be,    m1_be;
  logic [15:0] m0_addr,  m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ack,   m1_ack;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_be;
  logic [15:0] bus_rdata;
  logic [1:0]  bus_owner;

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_be, m1_be,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_rdata, m1_rdata, m0_ack, m1_ack,
    output bus_addr, bus_wdata, bus_we, bus_be, bus_owner,
    input  bus_rdata
  );

  // Environment side: both masters and the bus controller.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_be, m1_be,
    output m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_rdata, m1_rdata, m0_ack, m1_ack,
    input  bus_addr, bus_wdata, bus_we, bus_be, bus_owner,
    output bus_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie, the master not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,   // 0: m0 granted last, 1: m1 granted last
  output logic gnt0,
  output logic gnt1
);

  // Pure combinational priority flip based on the previous winner.
  always_comb begin
    gnt0 = req0 & (~req1 | last);
    gnt1 = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of a shared memory/IO bus with UART wait states.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus idle, sample requests, grant and latch one transfer
// ST_ACCESS | drive latched transfer; wait counter runs down to zero
// ST_ACK    | one-cycle ack to the granted master; requests ignored
module bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [15:0] UARTBASE  = UARTBASE_DEFAULT,
  parameter int unsigned UART_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_arbiter_if.slave  bus_if
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(UART_WAIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;       // granted master: 0 = m0, 1 = m1
  logic                we_q, we_d;
  logic [15:0]         bus_addr_q, bus_addr_d;
  logic [15:0]         bus_wdata_q, bus_wdata_d;
  logic                bus_we_q, bus_we_d;
  logic                bus_be_q, bus_be_d;
  logic [1:0]          bus_owner_q, bus_owner_d;
  logic [15:0]         m0_rdata_q, m0_rdata_d;
  logic [15:0]         m1_rdata_q, m1_rdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;

  logic                gnt0, gnt1;
  logic                req0_idle, req1_idle;
  logic [15:0]         sel_addr, sel_wdata;
  logic                sel_we, sel_be;
  logic [WAIT_W-1:0]   sel_wait;

  // Requests only count while idle; ACCESS and ACK ignore the masters.
  assign req0_idle = bus_if.m0_req & (state_q == ST_IDLE);
  assign req1_idle = bus_if.m1_req & (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req0 (req0_idle),
    .req1 (req1_idle),
    .last (last_q),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Mux the winning master's transfer fields and pick its wait count.
  always_comb begin
    sel_addr  = gnt1 ? bus_if.m1_addr  : bus_if.m0_addr;
    sel_wdata = gnt1 ? bus_if.m1_wdata : bus_if.m0_wdata;
    sel_we    = gnt1 ? bus_if.m1_we    : bus_if.m0_we;
    sel_be    = gnt1 ? bus_if.m1_be    : bus_if.m0_be;
    sel_wait  = in_uart_space(sel_addr, UARTBASE) ? WAIT_LOAD : '0;
  end

  // Next-state and next-output logic; bus outputs default to idle values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    we_d        = we_q;
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    bus_we_d    = 1'b0;
    bus_be_d    = 1'b0;
    bus_owner_d = OWNER_NONE;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 | gnt1) begin
          state_d     = ST_ACCESS;
          sel_d       = gnt1;
          last_d      = gnt1;
          we_d        = sel_we;
          cnt_d       = sel_wait;
          bus_addr_d  = sel_addr;
          bus_wdata_d = sel_wdata;
          bus_be_d    = sel_be;
          bus_owner_d = gnt1 ? OWNER_M1 : OWNER_M0;
          // Zero wait: the first ACCESS cycle is also the final one.
          bus_we_d    = sel_we & (sel_wait == '0);
        end
      end

      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - 1'b1;
          bus_addr_d  = bus_addr_q;
          bus_wdata_d = bus_wdata_q;
          bus_be_d    = bus_be_q;
          bus_owner_d = bus_owner_q;
          // Strobe lands in the cycle where the counter reads zero.
          bus_we_d    = we_q & (cnt_q == WAIT_W'(1));
        end else begin
          state_d = ST_ACK;
          if (!we_q) begin
            if (sel_q) m1_rdata_d = bus_if.bus_rdata;
            else       m0_rdata_d = bus_if.bus_rdata;
          end
          m0_ack_d = ~sel_q;
          m1_ack_d = sel_q;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 1'b0;
      bus_owner_q <= OWNER_NONE;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_owner_q <= bus_owner_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.bus_we    = bus_we_q;
  assign bus_if.bus_be    = bus_be_q;
  assign bus_if.bus_owner = bus_owner_q;
  assign bus_if.m0_rdata  = m0_rdata_q;
  assign bus_if.m1_rdata  = m1_rdata_q;
  assign bus_if.m0_ack    = m0_ack_q;
  assign bus_if.m1_ack    = m1_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter with a transfer-level reference model.
module tb_bus_arbiter;
  localparam logic [15:0] UB = 16'h0ff0;
  localparam int          UW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if ifc();

  bus_arbiter #(.UARTBASE(UB), .UART_WAIT(UW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who won last, and what each master last read.
  bit          model_last = 1'b1;
  logic [15:0] model_rd0  = '0;
  logic [15:0] model_rd1  = '0;

  // Observations from the most recent run_xfer.
  int          r_lat, r_we_cnt, r_we_cyc, r_ack0, r_ack1;
  logic [1:0]  r_owner, r_idle_owner;
  logic [15:0] r_addr, r_wdata, r_idle_addr;
  logic        r_be, r_idle_we;

  function automatic int model_winner(bit r0, bit r1);
    if (r0 && r1) return model_last ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  function automatic int model_lat(logic [15:0] a);
    return (a >= UB) ? 2 + UW : 2;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_last = 1'b1; model_rd0 = '0; model_rd1 = '0;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with it idle again.
  task automatic run_xfer(input bit r0, input bit r1, input bit we, input bit be,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdat, input bit drop_early);
    r_lat = -1; r_we_cnt = 0; r_we_cyc = -1; r_ack0 = 0; r_ack1 = 0;
    r_owner = 2'b11; r_addr = 'x; r_wdata = 'x; r_be = 1'bx;
    if (r0) begin ifc.m0_we = we; ifc.m0_be = be; ifc.m0_addr = addr; ifc.m0_wdata = wdata; end
    if (r1) begin ifc.m1_we = we; ifc.m1_be = be; ifc.m1_addr = addr; ifc.m1_wdata = wdata; end
    ifc.m0_req = r0; ifc.m1_req = r1; ifc.bus_rdata = rdat;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r_owner = ifc.bus_owner; r_addr = ifc.bus_addr;
        r_wdata = ifc.bus_wdata; r_be = ifc.bus_be;
        // Masters change their inputs mid-transfer; the latched values must hold.
        ifc.m0_addr = 16'($urandom); ifc.m1_addr = 16'($urandom);
        ifc.m0_wdata = 16'($urandom); ifc.m1_wdata = 16'($urandom);
        ifc.m0_we = 1'($urandom); ifc.m1_we = 1'($urandom);
        ifc.m0_be = 1'($urandom); ifc.m1_be = 1'($urandom);
        if (drop_early) begin
          if (r_owner == 2'b01) ifc.m0_req = 1'b0;
          if (r_owner == 2'b10) ifc.m1_req = 1'b0;
        end
      end
      if (ifc.bus_we) begin r_we_cnt++; r_we_cyc = k; end
      if (ifc.m0_ack) r_ack0++;
      if (ifc.m1_ack) r_ack1++;
      if (ifc.m0_ack || ifc.m1_ack) begin
        r_lat = k;
        if (ifc.m0_ack) ifc.m0_req = 1'b0;
        if (ifc.m1_ack) ifc.m1_req = 1'b0;
        break;
      end
    end
    if (r_lat < 0) begin ifc.m0_req = 1'b0; ifc.m1_req = 1'b0; end
    @(negedge clk);
    r_idle_owner = ifc.bus_owner; r_idle_addr = ifc.bus_addr; r_idle_we = ifc.bus_we;
    if (ifc.m0_ack) r_ack0++;
    if (ifc.m1_ack) r_ack1++;
  endtask

  task automatic test_reset();
    ifc.m0_req = 1'b1; ifc.m1_req = 1'b1;
    ifc.m0_addr = 16'h1234; ifc.m1_addr = 16'h4321;
    ifc.m0_wdata = 16'hffff; ifc.m1_wdata = 16'hffff;
    ifc.m0_we = 1'b1; ifc.m1_we = 1'b1; ifc.m0_be = 1'b1; ifc.m1_be = 1'b1;
    ifc.bus_rdata = 16'hdead;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ifc.bus_owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner got %b want 00", ifc.bus_owner); end
    n_tests++;
    if ({ifc.bus_addr, ifc.bus_wdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", ifc.bus_addr, ifc.bus_wdata);
    end
    n_tests++;
    if ({ifc.bus_we, ifc.bus_be, ifc.m0_ack, ifc.m1_ack} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctl got we%b be%b a0%b a1%b want 0", ifc.bus_we, ifc.bus_be, ifc.m0_ack, ifc.m1_ack);
    end
    n_tests++;
    if ({ifc.m0_rdata, ifc.m1_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", ifc.m0_rdata, ifc.m1_rdata);
    end
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    reset_n = 1'b1;
    model_last = 1'b1; model_rd0 = '0; model_rd1 = '0;
    @(negedge clk);
    n_tests++;
    if (ifc.bus_owner !== 2'b00) begin n_fail++; $display("FAIL idle_noreq_owner got %b want 00", ifc.bus_owner); end
  endtask

  task automatic test_ram_read();
    run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h1111, 16'hBEEF, 1'b0);
    model_last = 1'b0; model_rd0 = 16'hBEEF;
    n_tests++;
    if (r_lat !== 2) begin n_fail++; $display("FAIL ram_read_lat got %0d want 2", r_lat); end
    n_tests++;
    if (r_we_cnt !== 0) begin n_fail++; $display("FAIL ram_read_we got %0d want 0", r_we_cnt); end
    n_tests++;
    if (ifc.m0_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL ram_read_rdata got %h want BEEF", ifc.m0_rdata); end
    n_tests++;
    if (r_owner !== 2'b01 || r_addr !== 16'h0100) begin
      n_fail++; $display("FAIL ram_read_bus got owner %b addr %h want 01 0100", r_owner, r_addr);
    end
    n_tests++;
    if (r_ack0 !== 1 || r_ack1 !== 0) begin
      n_fail++; $display("FAIL ram_read_acks got %0d/%0d want 1/0", r_ack0, r_ack1);
    end
  endtask

  task automatic test_uart_write();
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 16'h0ff2, 16'h0041, 16'h7777, 1'b0);
    model_last = 1'b1;
    n_tests++;
    if (r_lat !== 5) begin n_fail++; $display("FAIL uart_write_lat got %0d want 5", r_lat); end
    n_tests++;
    if (r_we_cnt !== 1 || r_we_cyc !== 4) begin
      n_fail++; $display("FAIL uart_write_we got count %0d at %0d want 1 at 4", r_we_cnt, r_we_cyc);
    end
    n_tests++;
    if (r_wdata !== 16'h0041 || r_addr !== 16'h0ff2 || r_be !== 1'b1 || r_owner !== 2'b10) begin
      n_fail++; $display("FAIL uart_write_bus got %h %h %b %b want 0041 0ff2 1 10", r_wdata, r_addr, r_be, r_owner);
    end
    n_tests++;
    if (ifc.m1_rdata !== model_rd1 || ifc.m0_rdata !== model_rd0) begin
      n_fail++; $display("FAIL uart_write_rdata got %h/%h want %h/%h", ifc.m0_rdata, ifc.m1_rdata, model_rd0, model_rd1);
    end
    n_tests++;
    if (r_ack0 !== 0 || r_ack1 !== 1) begin
      n_fail++; $display("FAIL uart_write_acks got %0d/%0d want 0/1", r_ack0, r_ack1);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] addrs [3];
    int          want  [3];
    addrs[0] = 16'h0fef; want[0] = 2;
    addrs[1] = 16'h0ff0; want[1] = 2 + UW;
    addrs[2] = 16'hffff; want[2] = 2 + UW;
    foreach (addrs[i]) begin
      run_xfer(1'b1, 1'b0, 1'b1, 1'b0, addrs[i], 16'h00a0 + 16'(i), 16'h0, 1'b0);
      model_last = 1'b0;
      n_tests++;
      if (r_lat !== want[i] || r_we_cnt !== 1 || r_we_cyc !== want[i] - 1) begin
        n_fail++;
        $display("FAIL boundary_%h got lat %0d we %0d@%0d want lat %0d we 1@%0d",
                 addrs[i], r_lat, r_we_cnt, r_we_cyc, want[i], want[i] - 1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want_owner [4];
    logic [15:0] rd;
    want_owner[0] = 2'b01; want_owner[1] = 2'b10;
    want_owner[2] = 2'b01; want_owner[3] = 2'b10;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      rd = 16'($urandom);
      run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020 + 16'(i), 16'h0, rd, 1'b0);
      if (want_owner[i] == 2'b01) model_rd0 = rd; else model_rd1 = rd;
      n_tests++;
      if (r_owner !== want_owner[i] || r_ack0 !== int'(want_owner[i][0]) || r_ack1 !== int'(want_owner[i][1])) begin
        n_fail++;
        $display("FAIL rr_grant_%0d got owner %b acks %0d/%0d want %b", i, r_owner, r_ack0, r_ack1, want_owner[i]);
      end
      n_tests++;
      if (ifc.m0_rdata !== model_rd0 || ifc.m1_rdata !== model_rd1) begin
        n_fail++; $display("FAIL rr_rdata_%0d got %h/%h want %h/%h", i, ifc.m0_rdata, ifc.m1_rdata, model_rd0, model_rd1);
      end
    end
    model_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    int acks, wes;
    acks = 0; wes = 0;
    run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0, 16'h5A5A, 1'b0);
    model_last = 1'b0; model_rd0 = 16'h5A5A;
    ifc.m1_we = 1'b1; ifc.m1_be = 1'b0; ifc.m1_addr = 16'h0ff4; ifc.m1_wdata = 16'h00c3;
    ifc.m1_req = 1'b1;
    @(negedge clk);  // first ACCESS cycle
    if (ifc.bus_we) wes++;
    @(negedge clk);  // second ACCESS cycle
    if (ifc.bus_we) wes++;
    reset_n = 1'b0; ifc.m1_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ifc.m0_rdata !== 16'h0 || ifc.m1_rdata !== 16'h0) begin
      n_fail++; $display("FAIL midreset_rdata got %h/%h want 0/0", ifc.m0_rdata, ifc.m1_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_last = 1'b1; model_rd0 = '0; model_rd1 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifc.bus_we) wes++;
      if (ifc.m0_ack || ifc.m1_ack) acks++;
    end
    n_tests++;
    if (acks !== 0 || wes !== 0) begin
      n_fail++; $display("FAIL midreset_abort got acks %0d we %0d want 0 0", acks, wes);
    end
    run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h1357, 1'b0);
    model_last = 1'b0; model_rd0 = 16'h1357;
    n_tests++;
    if (r_owner !== 2'b01 || r_ack0 !== 1) begin
      n_fail++; $display("FAIL midreset_next_grant got owner %b ack0 %0d want 01 1", r_owner, r_ack0);
    end
    // Loser still requesting gets the following slot.
    run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h2468, 1'b0);
    model_last = 1'b1; model_rd1 = 16'h2468;
    n_tests++;
    if (r_owner !== 2'b10 || ifc.m1_rdata !== 16'h2468) begin
      n_fail++; $display("FAIL midreset_follow got owner %b rdata %h want 10 2468", r_owner, ifc.m1_rdata);
    end
  endtask

  task automatic test_random();
    int          mode, win, nxfer;
    bit          r0, r1, we, be, drop;
    logic [15:0] addr, wdata, rd;
    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 2));
      r0 = (mode != 1); r1 = (mode != 0);
      nxfer = (r0 && r1) ? 2 : 1;
      for (int x = 0; x < nxfer; x++) begin
        we = 1'($urandom); be = 1'($urandom); drop = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 4))
          0: addr = UB - 16'd1;
          1: addr = UB;
          2: addr = UB + 16'($urandom_range(1, 64));
          3: addr = 16'($urandom_range(0, 16'h0fef));
          default: addr = 16'($urandom);
        endcase
        wdata = 16'($urandom); rd = 16'($urandom);
        win = model_winner(r0, r1);
        run_xfer(r0, r1, we, be, addr, wdata, rd, drop);
        model_last = (win == 1);
        if (!we) begin
          if (win == 1) model_rd1 = rd; else model_rd0 = rd;
        end
        n_tests++;
        if (r_lat !== model_lat(addr) || r_we_cnt !== int'(we) || (we && r_we_cyc !== model_lat(addr) - 1)) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d_timing addr %h we %b got lat %0d we %0d@%0d want lat %0d",
                   it, x, addr, we, r_lat, r_we_cnt, r_we_cyc, model_lat(addr));
        end
        n_tests++;
        if (r_owner !== ((win == 1) ? 2'b10 : 2'b01) || r_addr !== addr || r_wdata !== wdata || r_be !== be) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d_bus got %b %h %h %b want m%0d %h %h %b",
                   it, x, r_owner, r_addr, r_wdata, r_be, win, addr, wdata, be);
        end
        n_tests++;
        if (r_ack0 !== ((win == 0) ? 1 : 0) || r_ack1 !== ((win == 1) ? 1 : 0)) begin
          n_fail++; $display("FAIL rand_%0d_%0d_acks got %0d/%0d want winner m%0d", it, x, r_ack0, r_ack1, win);
        end
        n_tests++;
        if (ifc.m0_rdata !== model_rd0 || ifc.m1_rdata !== model_rd1) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d_rdata got %h/%h want %h/%h", it, x, ifc.m0_rdata, ifc.m1_rdata, model_rd0, model_rd1);
        end
        n_tests++;
        if (r_idle_owner !== 2'b00 || r_idle_addr !== 16'h0 || r_idle_we !== 1'b0) begin
          n_fail++; $display("FAIL rand_%0d_%0d_idle got %b %h %b want 00 0000 0", it, x, r_idle_owner, r_idle_addr, r_idle_we);
        end
        if (win == 1) r1 = 1'b0; else r0 = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    ifc.m0_we = 1'b0; ifc.m1_we = 1'b0; ifc.m0_be = 1'b0; ifc.m1_be = 1'b0;
    ifc.m0_addr = '0; ifc.m1_addr = '0; ifc.m0_wdata = '0; ifc.m1_wdata = '0;
    ifc.bus_rdata = '0;
    test_reset();
    test_ram_read();
    test_uart_write();
    test_boundary();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter UARTBASE, default 16'h0ff0: first byte address decoded as UART space.
REQ-002 SHALL have parameter UART_WAIT, default 3: extra ACCESS cycles for UART-space transfers (range 0-15).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have ports m0_req, m1_req  input  1 each: master transfer request, held until ack.
REQ-006 SHALL have ports m0_we, m1_we  input  1 each: write (1) or read (0).
REQ-007 SHALL have ports m0_be, m1_be  input  1 each: byte access (1) or word access (0).
REQ-008 SHALL have ports m0_addr, m1_addr  input  16 each: byte address.
REQ-009 SHALL have ports m0_wdata, m1_wdata  input  16 each: write data.
REQ-010 SHALL have ports m0_rdata, m1_rdata  output  16 each: registered read data.
REQ-011 SHALL have ports m0_ack, m1_ack  output  1 each: one-cycle completion pulse.
REQ-012 SHALL have ports bus_addr  output  16, bus_wdata  output  16, bus_we  output  1, bus_be  output  1: to memory/IO bus controller.
REQ-013 SHALL have port bus_rdata  input  16: read data from memory/IO bus controller (combinational).
REQ-014 SHALL have port bus_owner  output  2: 00 none, 01 m0, 10 m1.

Function
REQ-015 SHALL implement states IDLE, ACCESS, ACK.
REQ-016 In IDLE with no req: stay IDLE; bus_addr/bus_wdata = 0, bus_we = bus_be = 0, bus_owner = 00.
REQ-017 In IDLE with one req: grant that master, latch its addr/we/be/wdata, go to ACCESS next cycle.
REQ-018 In IDLE with both reqs: round-robin; grant the master not granted last; last_grant updates on every grant.
REQ-019 On grant, wait counter SHALL load UART_WAIT if latched addr >= UARTBASE, else 0.
REQ-020 In ACCESS, bus outputs SHALL drive latched values and bus_owner the granted master; master inputs ignored.
REQ-021 In ACCESS, counter decrements each cycle while nonzero; counter == 0 marks the final ACCESS cycle.
REQ-022 bus_we SHALL be asserted only in the final ACCESS cycle and only for a write transfer, giving exactly one write strobe.
REQ-023 In the final ACCESS cycle, a read SHALL capture bus_rdata into the granted master's rdata register; a write leaves rdata unchanged.
REQ-024 Next state after the final ACCESS cycle is ACK: granted master's ack = 1 for exactly one cycle; bus outputs return to idle values.
REQ-025 ACK SHALL always go to IDLE; requests are not sampled in ACK, so at least one IDLE cycle separates transfers.
REQ-026 Latency: RAM transfer granted from IDLE in cycle t gives ack in t+2; UART transfer gives ack in t+2+UART_WAIT.
REQ-027 A master dropping req before ack SHALL not abort the transfer; ack is still issued.
REQ-028 Ungranted master's ack SHALL stay 0 and its rdata SHALL hold.
REQ-029 Address compare SHALL be unsigned 16-bit; UARTBASE itself is UART space, UARTBASE-1 is RAM space.

Reset
REQ-030 With reset_n = 0 at a rising edge: state = IDLE, counter = 0, latches = 0, m0/m1_rdata = 0, acks = 0, bus outputs idle, last_grant = m1 (so m0 wins first tie).
REQ-031 Reset in ACCESS or ACK SHALL abandon the transfer: no ack, no further bus_we.

Structure
REQ-032 Shared package bus_pkg SHALL hold the state enumeration, bus_owner encodings, and the default UARTBASE constant.
REQ-033 A two-way round-robin sub-module rr_arb2 (inputs req0/req1/last, outputs gnt0/gnt1) SHALL implement REQ-018.

Verification
REQ-034 m0 read at 16'h0100, bus_rdata = 16'hBEEF -> bus_we never high, m0_ack in t+2, m0_rdata = 16'hBEEF.
REQ-035 m1 write at 16'h0ff2, wdata 16'h0041, UART_WAIT = 3 -> bus_we high exactly 1 cycle at t+4, m1_ack at t+5.
REQ-036 m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1; bus_owner 01, 10, 01, 10.
REQ-037 m0 write at 16'h0fef vs 16'h0ff0 -> ack latency 2 vs 2+UART_WAIT cycles.
REQ-038 reset_n low in second ACCESS cycle of a UART write -> no ack, bus_we stays 0, m0_rdata = m1_rdata = 0, next grant goes to m0.
